// File: rtl/lfsr_checker_pkg.sv
// Shared definitions for the 8-bit Fibonacci LFSR generator/checker pair.
// The next-state function lives here so both ends use the same rule.
package lfsr_pkg;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_e;

    localparam logic [7:0] DEFAULT_TAPS = 8'b0001_1101;

    // Right shift, parity of the tapped bits enters the MSB.
    function automatic logic [7:0] lfsr_next(input logic [7:0] x, input logic [7:0] taps);
        return {^(x & taps), x[7:1]};
    endfunction

endpackage

// File: rtl/lfsr_checker_bcd7seg.sv
// Team hex-to-seven-segment decoder: active-high segments, seg_o = {g,f,e,d,c,b,a}.
// Covers the full 0-F range so it can display raw hex counters.
module bcd7seg (
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    always_comb begin
        case (hex_i)
            4'h0:    seg_o = 7'h3F;
            4'h1:    seg_o = 7'h06;
            4'h2:    seg_o = 7'h5B;
            4'h3:    seg_o = 7'h4F;
            4'h4:    seg_o = 7'h66;
            4'h5:    seg_o = 7'h6D;
            4'h6:    seg_o = 7'h7D;
            4'h7:    seg_o = 7'h07;
            4'h8:    seg_o = 7'h7F;
            4'h9:    seg_o = 7'h6F;
            4'hA:    seg_o = 7'h77;
            4'hB:    seg_o = 7'h7C;
            4'hC:    seg_o = 7'h39;
            4'hD:    seg_o = 7'h5E;
            4'hE:    seg_o = 7'h79;
            default: seg_o = 7'h71;
        endcase
    end

endmodule

// File: rtl/lfsr_checker.sv
// PRBS receive checker: self-synchronises to an 8-bit Fibonacci LFSR stream,
// flags/counts mismatches while locked and shows the count on two hex digits.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter logic [7:0] TAPS     = DEFAULT_TAPS,
    parameter int         LOCK_CNT = 3,
    parameter int         LOSS_CNT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic       clr_err,
    output logic       locked,
    output logic       err_pulse,
    output logic [7:0] err_count,
    output logic [6:0] seg_hi,
    output logic [6:0] seg_lo
);

    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int BAD_W   = $clog2(LOSS_CNT + 1);

    state_e               state_q, state_d;
    logic                 seed_q, seed_d;
    logic [7:0]           pred_q, pred_d;
    logic [MATCH_W-1:0]   match_run_q, match_run_d;
    logic [BAD_W-1:0]     bad_run_q, bad_run_d;
    logic                 err_pulse_q, err_pulse_d;
    logic [7:0]           err_count_q, err_count_d;

    always_comb begin
        // NOTE: every next-state signal gets a hold default first so no latch is inferred.
        state_d     = state_q;
        seed_d      = seed_q;
        pred_d      = pred_q;
        match_run_d = match_run_q;
        bad_run_d   = bad_run_q;
        err_pulse_d = 1'b0;
        err_count_d = err_count_q;

        if (in_valid) begin
            case (state_q)
                SEARCH: begin
                    if (seed_q && in_data == pred_q) begin
                        pred_d = lfsr_next(pred_q, TAPS);
                        if (match_run_q == MATCH_W'(LOCK_CNT - 1)) begin
                            state_d     = LOCKED;
                            match_run_d = '0;
                            bad_run_d   = '0;
                        end else begin
                            match_run_d = match_run_q + MATCH_W'(1);
                        end
                    end else begin
                        // Zero is the lock-up state, so it can never seed the predictor.
                        seed_d      = (in_data != 8'h00);
                        pred_d      = lfsr_next(in_data, TAPS);
                        match_run_d = '0;
                    end
                end
                LOCKED: begin
                    pred_d = lfsr_next(pred_q, TAPS);
                    if (in_data == pred_q) begin
                        bad_run_d = '0;
                    end else begin
                        err_pulse_d = 1'b1;
                        if (err_count_q != 8'hFF) begin
                            err_count_d = err_count_q + 8'd1;
                        end
                        if (bad_run_q == BAD_W'(LOSS_CNT - 1)) begin
                            state_d     = SEARCH;
                            bad_run_d   = '0;
                            match_run_d = '0;
                            seed_d      = (in_data != 8'h00);
                            pred_d      = lfsr_next(in_data, TAPS);
                        end else begin
                            bad_run_d = bad_run_q + BAD_W'(1);
                        end
                    end
                end
                default: state_d = SEARCH;
            endcase
        end

        if (clr_err) begin
            err_count_d = 8'h00;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= SEARCH;
            seed_q      <= 1'b0;
            pred_q      <= 8'h00;
            match_run_q <= '0;
            bad_run_q   <= '0;
            err_pulse_q <= 1'b0;
            err_count_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            seed_q      <= seed_d;
            pred_q      <= pred_d;
            match_run_q <= match_run_d;
            bad_run_q   <= bad_run_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
        end
    end

    assign locked    = (state_q == LOCKED);
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;

    bcd7seg u_seg_hi (
        .hex_i (err_count_q[7:4]),
        .seg_o (seg_hi)
    );

    bcd7seg u_seg_lo (
        .hex_i (err_count_q[3:0]),
        .seg_o (seg_lo)
    );

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: lock, single error, loss/relock, search
// robustness, async reset, saturation and clear-vs-mismatch priority.
module tb_lfsr_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       clr_err = 1'b0;
    logic       locked;
    logic       err_pulse;
    logic [7:0] err_count;
    logic [6:0] seg_hi;
    logic [6:0] seg_lo;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_F = 7'h71;

    always #5 clk = ~clk;

    lfsr_checker dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .clr_err   (clr_err),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count),
        .seg_hi    (seg_hi),
        .seg_lo    (seg_lo)
    );

    // Reference successor written from the tap positions 4,3,2,0.
    function automatic logic [7:0] nx(input logic [7:0] x);
        return {x[4] ^ x[3] ^ x[2] ^ x[0], x[7:1]};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive on the falling edge, outputs settle 1 ns after the rising edge.
    task automatic cyc(input logic v, input logic [7:0] d, input logic c);
        @(negedge clk);
        in_valid = v;
        in_data  = d;
        clr_err  = c;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        cyc(1'b1, d, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0;
        clr_err  = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [7:0] p;

    initial begin
        do_reset();
        check("rst_locked", locked, 0);
        check("rst_pulse", err_pulse, 0);
        check("rst_count", err_count, 0);
        check("rst_seg_hi", seg_hi, SEG_0);
        check("rst_seg_lo", seg_lo, SEG_0);

        // Lock on 01,80,40,20
        send(8'h01); check("lock_01", locked, 0); check("lock_pulse01", err_pulse, 0);
        send(8'h80); check("lock_80", locked, 0); check("lock_pulse80", err_pulse, 0);
        send(8'h40); check("lock_40", locked, 0); check("lock_pulse40", err_pulse, 0);
        send(8'h20); check("lock_20", locked, 1); check("lock_pulse20", err_pulse, 0);
        check("lock_count", err_count, 0);

        // Single error: 11 instead of 10, then 88, C4
        send(8'h11);
        check("se_pulse", err_pulse, 1); check("se_count", err_count, 1); check("se_locked", locked, 1);
        send(8'h88);
        check("se_pulse_off", err_pulse, 0); check("se_count88", err_count, 1); check("se_locked88", locked, 1);
        send(8'hC4);
        check("se_pulseC4", err_pulse, 0); check("se_countC4", err_count, 1);

        cyc(1'b0, 8'h00, 1'b1);
        check("clr_idle", err_count, 0);
        check("clr_keeps_lock", locked, 1);

        // Loss: predictions E2,71,38,1C; send 5A..5D
        send(8'h5A); check("loss1_locked", locked, 1); check("loss1_count", err_count, 1);
        send(8'h5B); check("loss2_locked", locked, 1);
        send(8'h5C); check("loss3_locked", locked, 1); check("loss3_count", err_count, 3);
        send(8'h5D);
        check("loss4_locked", locked, 0); check("loss4_count", err_count, 4); check("loss4_pulse", err_pulse, 1);
        // 5D seeds: continuation 2E,17,8B
        send(8'h2E); check("relock_2E", locked, 0); check("relock_pulse", err_pulse, 0);
        send(8'h17); check("relock_17", locked, 0);
        send(8'h8B); check("relock_8B", locked, 1); check("relock_count", err_count, 4);

        // Build err_count=3 while locked (pred now 45)
        cyc(1'b0, 8'h00, 1'b1);
        p = 8'h45;
        for (int i = 0; i < 3; i++) begin
            send(p ^ 8'hFF); p = nx(p);
            send(p);         p = nx(p);
        end
        check("pre_ar_count", err_count, 3);
        check("pre_ar_locked", locked, 1);

        // Asynchronous reset between edges
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("ar_locked", locked, 0);
        check("ar_count", err_count, 0);
        check("ar_seg_lo", seg_lo, SEG_0);
        @(negedge clk);
        rst = 1'b0;
        send(8'h80); check("ar_80", locked, 0);
        send(8'h40); check("ar_40", locked, 0);
        send(8'h20); check("ar_20", locked, 0);
        send(8'h10); check("ar_10", locked, 1);

        // Search robustness: zeros and idle gap
        do_reset();
        send(8'h00); send(8'h00);
        send(8'h01); check("sr_01", locked, 0);
        idle(5);     check("sr_gap", locked, 0);
        send(8'h80);
        send(8'h40); check("sr_40", locked, 0);
        send(8'h20); check("sr_20", locked, 1); check("sr_count", err_count, 0);

        // Saturation: 300 isolated mismatches
        p = 8'h10;
        for (int i = 0; i < 300; i++) begin
            send(p ^ 8'h01); p = nx(p);
            send(p);         p = nx(p);
        end
        check("sat_count", err_count, 8'hFF);
        check("sat_locked", locked, 1);
        check("sat_seg_hi", seg_hi, SEG_F);
        check("sat_seg_lo", seg_lo, SEG_F);

        // Clear in the same cycle as a mismatch
        cyc(1'b1, p ^ 8'h01, 1'b1); p = nx(p);
        check("clrmis_count", err_count, 0);
        check("clrmis_pulse", err_pulse, 1);
        check("clrmis_seg_hi", seg_hi, SEG_0);
        check("clrmis_seg_lo", seg_lo, SEG_0);
        send(p);
        check("post_clr_pulse", err_pulse, 0);
        check("post_clr_locked", locked, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
